// File: rtl/hazard_unit_pkg.sv
// Shared core definitions for the hazard controller: FSM encoding, register
// index width and the hard-wired zero register.
package hazard_unit_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_MEM_WAIT
  } hz_state_e;

  // A load in EX feeds an operand the ID instruction actually reads; x0 never hazards.
  function automatic logic load_use_hit(
    input logic                 mem_read,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs1,
    input logic                 uses_rs1,
    input logic [REG_IDX_W-1:0] rs2,
    input logic                 uses_rs2
  );
    return mem_read && (rd != X0) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage RV32 core: data-memory freezes,
// EX-resolved redirects with a two-cycle flush, and load-use interlocks.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16,
  parameter int unsigned FLUSH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_redirect,
  input  logic                   mem_req,
  input  logic                   dmem_ready,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   ifid_clr,
  output logic                   idex_stall,
  output logic                   idex_clr,
  output logic                   exmem_stall,
  output logic                   memwb_clr,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_events
);

  hz_state_e state_q, state_d;
  logic      saved_flush_q, saved_flush_d;

  logic freeze;
  logic in_flush;
  logic lu_hit;
  logic redirect_take;

  logic pc_stall_c, ifid_stall_c, ifid_clr_c, idex_stall_c;
  logic idex_clr_c, exmem_stall_c, memwb_clr_c;

  assign freeze = mem_req && !dmem_ready;
  assign lu_hit = load_use_hit(ex_mem_read, ex_rd, id_rs1, id_uses_rs1,
                               id_rs2, id_uses_rs2);

  // On the release cycle MEM_WAIT behaves as the state it froze, so a pending
  // redirect (or the outstanding flush cycle) is acted on without extra delay.
  assign in_flush = (state_q == ST_FLUSH) ||
                    ((state_q == ST_MEM_WAIT) && saved_flush_q);

  always_comb begin
    state_d       = state_q;
    saved_flush_d = saved_flush_q;
    redirect_take = 1'b0;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_clr_c    = 1'b0;
    idex_stall_c  = 1'b0;
    idex_clr_c    = 1'b0;
    exmem_stall_c = 1'b0;
    memwb_clr_c   = 1'b0;

    if (freeze) begin
      pc_stall_c    = 1'b1;
      ifid_stall_c  = 1'b1;
      idex_stall_c  = 1'b1;
      exmem_stall_c = 1'b1;
      memwb_clr_c   = 1'b1;
      state_d       = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) begin
        saved_flush_d = (state_q == ST_FLUSH);
      end
    end else if (in_flush) begin
      ifid_clr_c    = 1'b1;
      state_d       = ST_RUN;
      saved_flush_d = 1'b0;
    end else if (ex_redirect) begin
      ifid_clr_c    = 1'b1;
      idex_clr_c    = 1'b1;
      redirect_take = 1'b1;
      state_d       = ST_FLUSH;
      saved_flush_d = 1'b0;
    end else begin
      state_d       = ST_RUN;
      saved_flush_d = 1'b0;
      if (lu_hit) begin
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        idex_clr_c   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      saved_flush_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      saved_flush_q <= saved_flush_d;
    end
  end

  // While reset is held the pipeline is filled with bubbles and nothing stalls.
  assign pc_stall    = rst_n && pc_stall_c;
  assign ifid_stall  = rst_n && ifid_stall_c;
  assign idex_stall  = rst_n && idex_stall_c;
  assign exmem_stall = rst_n && exmem_stall_c;
  assign ifid_clr    = !rst_n || ifid_clr_c;
  assign idex_clr    = !rst_n || idex_clr_c;
  assign memwb_clr   = !rst_n || memwb_clr_c;

  sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pc_stall),
    .count(stall_cycles)
  );

  sat_counter #(
    .WIDTH(FLUSH_CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (redirect_take && rst_n),
    .count(flush_events)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; a narrow-counter instance shares the stimulus
// so saturation is reachable in a few cycles.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic       mem_req, dmem_ready;

  logic        pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr, exmem_stall, memwb_clr;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_events;

  logic        s_pc_stall, s_ifid_stall, s_ifid_clr, s_idex_stall, s_idex_clr;
  logic        s_exmem_stall, s_memwb_clr;
  logic [1:0]  s_stall_cycles;
  logic [1:0]  s_flush_events;

  int checks = 0;
  int errors = 0;

  // {pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr, exmem_stall, memwb_clr}
  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_RESET  = 7'b0010101;
  localparam logic [6:0] O_LU     = 7'b1100100;
  localparam logic [6:0] O_REDIR  = 7'b0010100;
  localparam logic [6:0] O_FLUSH  = 7'b0010000;
  localparam logic [6:0] O_FREEZE = 7'b1101011;

  always #5 clk = ~clk;

  hazard_unit #(
    .STALL_CNT_W(16),
    .FLUSH_CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_clr(ifid_clr),
    .idex_stall(idex_stall), .idex_clr(idex_clr), .exmem_stall(exmem_stall),
    .memwb_clr(memwb_clr), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  hazard_unit #(
    .STALL_CNT_W(2),
    .FLUSH_CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_clr(s_ifid_clr),
    .idex_stall(s_idex_stall), .idex_clr(s_idex_clr), .exmem_stall(s_exmem_stall),
    .memwb_clr(s_memwb_clr), .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr,
              exmem_stall, memwb_clr}, {25'd0, exp});
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Advance one clock, leaving time 1 unit after the edge for new inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk_out("reset_outputs", O_RESET);
    chk("reset_stall_cnt", {16'd0, stall_cycles}, 32'd0);
    chk("reset_flush_cnt", {24'd0, flush_events}, 32'd0);
    tick();
    #3 rst_n = 1'b1;
    #1;
    chk_out("idle_run", O_IDLE);
    tick();

    // load-use on rs2
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #1 chk_out("loaduse_rs2", O_LU);
    tick();
    idle_inputs();
    #1 chk_out("loaduse_bubble", O_IDLE);
    chk("loaduse_stall_cnt", {16'd0, stall_cycles}, 32'd1);

    // x0 destination never hazards
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1 chk_out("x0_no_stall", O_IDLE);
    // matching but unused operand
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
    #1 chk_out("unused_rs1_no_stall", O_IDLE);
    // same registers, now used
    id_uses_rs1 = 1'b1;
    #1 chk_out("loaduse_rs1", O_LU);
    tick();
    idle_inputs();
    #1 chk("stall_cnt_2", {16'd0, stall_cycles}, 32'd2);

    // redirect, then FLUSH ignores redirect and load-use
    ex_redirect = 1'b1;
    #1 chk_out("redirect", O_REDIR);
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    #1 chk_out("flush_cycle", O_FLUSH);
    tick();
    idle_inputs();
    #1 chk_out("after_flush_run", O_IDLE);
    chk("flush_cnt_1", {24'd0, flush_events}, 32'd1);

    // redirect and load-use together: redirect wins
    ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    #1 chk_out("redirect_over_loaduse", O_REDIR);
    tick();
    idle_inputs();
    #1 chk_out("flush_cycle_2", O_FLUSH);
    tick();
    chk("stall_cnt_no_lu", {16'd0, stall_cycles}, 32'd2);
    chk("flush_cnt_2", {24'd0, flush_events}, 32'd2);

    // freeze for 3 cycles with redirect held
    mem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_out($sformatf("freeze_%0d", i), O_FREEZE);
      tick();
    end
    dmem_ready = 1'b1;
    #1 chk_out("freeze_release_redirect", O_REDIR);
    tick();
    idle_inputs();
    #1 chk_out("freeze_release_flush", O_FLUSH);
    chk("freeze_stall_cnt", {16'd0, stall_cycles}, 32'd5);
    chk("freeze_flush_cnt", {24'd0, flush_events}, 32'd3);
    tick();

    // freeze entered from FLUSH returns to FLUSH, redirect still ignored there
    ex_redirect = 1'b1;
    #1 chk_out("redirect_3", O_REDIR);
    tick();
    mem_req = 1'b1; dmem_ready = 1'b0;
    #1 chk_out("freeze_in_flush", O_FREEZE);
    tick();
    dmem_ready = 1'b1;
    #1 chk_out("release_to_flush", O_FLUSH);
    tick();
    idle_inputs();
    #1 chk_out("flush_resolved_run", O_IDLE);
    chk("flush_cnt_4", {24'd0, flush_events}, 32'd4);
    chk("stall_cnt_6", {16'd0, stall_cycles}, 32'd6);

    // async reset between edges while in FLUSH
    ex_redirect = 1'b1;
    #1 tick();
    idle_inputs();
    #1 chk_out("pre_reset_flush", O_FLUSH);
    #1 rst_n = 1'b0;
    #1;
    chk_out("async_reset_outputs", O_RESET);
    chk("async_reset_stall_cnt", {16'd0, stall_cycles}, 32'd0);
    chk("async_reset_flush_cnt", {24'd0, flush_events}, 32'd0);
    tick();
    #2 rst_n = 1'b1;
    #1 chk_out("post_reset_run", O_IDLE);
    tick();

    // saturation on the narrow instance, main keeps counting
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    idle_inputs();
    tick();
    chk("sat_stall_cnt", {30'd0, s_stall_cycles}, 32'd3);
    chk("main_stall_cnt_5", {16'd0, stall_cycles}, 32'd5);
    for (int i = 0; i < 4; i++) begin
      ex_redirect = 1'b1;
      tick();
      ex_redirect = 1'b0;
      tick();
    end
    chk("sat_flush_cnt", {30'd0, s_flush_events}, 32'd3);
    chk("main_flush_cnt_4", {24'd0, flush_events}, 32'd4);
    chk("sat_outputs_idle", {31'd0, s_pc_stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RV32 core. It sits beside the ID/EX pipeline register and generates the `stall` and `clr` controls that the IF/ID, ID/EX and EX/MEM registers consume. It handles three cases: load-use interlocks, control-flow redirects (two-cycle flush for the registered instruction memory) and data-memory wait freezes. It also keeps saturating performance counters for stall and flush activity.

## Interface
Parameters:
- `STALL_CNT_W`, 16: width of the stall-cycle counter.
- `FLUSH_CNT_W`, 8: width of the flush-event counter.

Ports:
- `clk`  in  1  core clock; all state updates on posedge.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  ID instruction actually reads rs1 / rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  EX instruction is a load.
- `ex_redirect`  in  1  taken branch or jump resolved in EX.
- `mem_req`  in  1  MEM-stage instruction is accessing data memory.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_stall`  out  1  hold PC.
- `ifid_stall`  out  1  hold IF/ID.
- `ifid_clr`  out  1  clear IF/ID.
- `idex_stall`  out  1  hold ID/EX.
- `idex_clr`  out  1  clear ID/EX (bubble).
- `exmem_stall`  out  1  hold EX/MEM.
- `memwb_clr`  out  1  insert bubble into MEM/WB.
- `stall_cycles`  out  STALL_CNT_W  count of cycles with `pc_stall`=1; saturates at all-ones.
- `flush_events`  out  FLUSH_CNT_W  count of accepted redirects; saturates.

## Operation
FSM states: RUN, FLUSH, MEM_WAIT. Reset state is RUN.

- **freeze** = `mem_req` & !`dmem_ready`.
  - From RUN or FLUSH, freeze moves to MEM_WAIT.
  - MEM_WAIT stays while freeze holds.
  - On release, return to FLUSH if the frozen state was FLUSH, otherwise RUN. One saved bit holds this.
  - During freeze: `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall` and `memwb_clr` are all 1. All other clr outputs are 0.
- **redirect**: taken when `ex_redirect` is set, there is no freeze, and the state is RUN.
  - Outputs: `ifid_clr`=1, `idex_clr`=1, no stalls.
  - Next state FLUSH; `flush_events` increments.
  - A redirect held during freeze is acted on in the cycle freeze releases.
- **FLUSH** (one cycle, no freeze):
  - `ifid_clr`=1 discards the wrong-path fetch still in flight.
  - `ex_redirect` and load-use detection are ignored.
  - Next state RUN.
- **load-use**: applies only in RUN with no freeze and no redirect.
  - Condition: `ex_mem_read` & `ex_rd`≠0 & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
  - Outputs: `pc_stall`=1, `ifid_stall`=1, `idex_clr`=1. State stays RUN.
  - The bubble breaks the condition on the next cycle, so each load-use costs exactly one stall.
- **Priority**: freeze > redirect > load-use.
- Never assert stall and clr on the same register in the same cycle.
- Counters update on posedge. `stall_cycles` increments whenever `pc_stall`=1 and the counter is not saturated.

## Timing
- All control outputs are combinational from the current state and inputs, valid in the same cycle. There is no added latency.
- While `rst_n`=0: state RUN, both counters 0, all stall outputs 0, and `ifid_clr`, `idex_clr`, `memwb_clr` = 1 so the pipeline fills with bubbles.
- Reset asserted mid-FLUSH or mid-MEM_WAIT returns to RUN immediately. The saved FLUSH bit clears.
- Redirect cost: 2 bubbles (redirect cycle plus FLUSH). Load-use cost: 1 bubble. Freeze cost: N cycles, where N = cycles with `dmem_ready`=0.

## Structure
- Shared core package holds:
  - the FSM state enum (RUN/FLUSH/MEM_WAIT);
  - register-index width 5;
  - the `x0` constant.
- A sub-module `sat_counter` (parameterised width, increment enable, async active-low reset) is used for both counters.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 → one cycle of `pc_stall`=`ifid_stall`=`idex_clr`=1. Next cycle EX is a bubble and outputs return to 0. `stall_cycles`=1.
- **x0 and unused operand:** `ex_rd`=0 with a matching rs1 → no stall. `id_rs1`==`ex_rd`=7 with `id_uses_rs1`=0 → no stall.
- **Redirect:** `ex_redirect`=1 in RUN → `ifid_clr`=`idex_clr`=1. Next cycle (FLUSH) `ifid_clr`=1 only, then RUN. `flush_events`=1.
- **Redirect plus load-use in the same cycle** → redirect outputs only, no `pc_stall`.
- **Freeze:** `mem_req`=1, `dmem_ready`=0 for 3 cycles, with `ex_redirect`=1 held → 3 cycles of all stalls plus `memwb_clr`. Redirect is then taken in the release cycle. `stall_cycles`=3, `flush_events`=1.
- **Async reset mid-FLUSH:** drop `rst_n` between clock edges → outputs immediately show the reset values, counters 0, state RUN after release. Also preset `stall_cycles` to 0xFFFF and stall → value stays 0xFFFF.
